instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Byte-stream program loader: the write side of the instruction memory that
//  pc_instruction reads. Takes a count byte plus 3 bytes per 20-bit instruction
//  word, packs each word as {opcode[3:0], first[7:0], second[7:0]}, and writes it
//  to consecutive instruction-memory addresses from 0. Holds the CPU while loading.
// PARAMETERS
//  ADDR_W   5    instruction-memory address width; DEPTH = 2**ADDR_W words
//  INSTR_W  20   instruction word width; fixed at 20, other values unsupported
// PORTS
//  clk       in   1        rising-edge clock
//  reset     in   1        asynchronous, active-low reset
//  start     in   1        one-cycle request to begin a load; sampled only in IDLE
//  in_valid  in   1        in_data holds a byte
//  in_data   in   8        stream byte
//  in_ready  out  1        loader can accept a byte; transfer = in_valid & in_ready
//  wr_en     out  1        instruction-memory write strobe, one cycle per word
//  wr_addr   out  ADDR_W   write address
//  wr_data   out  INSTR_W  write word {op, first, second}
//  cpu_hold  out  1        high while a load is in progress; drives the PC hold
//  done      out  1        one-cycle pulse when a load finishes normally
//  err       out  1        sticky error flag; cleared when a start is accepted
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE. All outputs 0: in_ready, wr_en, wr_addr,
//    wr_data, cpu_hold, done, err. Memory contents are untouched.
//  - All outputs are registered or decoded from the state register only; there is
//    no combinational path from inputs to outputs.
//  - IDLE: start=1 -> COUNT and clear err; start in any other state is ignored.
//  - cpu_hold = (state != IDLE); it goes high the cycle after start is accepted.
//  - COUNT (in_ready=1): a transfer latches N=in_data and clears word_cnt.
//      N=0       -> DONE; no writes occur.
//      N>DEPTH   -> set err -> IDLE; no writes occur.
//      otherwise -> B0.
//  - B0/B1/B2 (in_ready=1): each state waits for a transfer.
//      B0 latches op=in_data[3:0]; if in_data[7:4]!=0, set err (upper nibble
//      dropped, word still written). B1 latches first. B2 latches second, then
//      moves to WRITE.
//  - in_valid=0 stalls in the current state indefinitely; there is no timeout.
//  - WRITE (in_ready=0): wr_en=1 for exactly one cycle, with wr_addr=word_cnt and
//    wr_data={op,first,second}; word_cnt increments.
//      If word_cnt+1==N -> DONE, else -> B0.
//  - Latency: the write strobe is asserted the cycle after the third byte's transfer.
//  - Throughput: at most 1 word per 4 cycles.
//  - DONE: done=1 and cpu_hold=1 for this one cycle, then -> IDLE (cpu_hold=0).
//  - word_cnt is ADDR_W+1 bits wide, so N=DEPTH fills addresses 0..DEPTH-1 with no
//    wrap. wr_addr never exceeds DEPTH-1.
//  - wr_addr and wr_data hold their last values when wr_en=0.
//  - Reset mid-load: immediate IDLE, cpu_hold=0, no further writes. Words already
//    written stay in memory; a partially assembled word is discarded.
//  - Bytes presented while in_ready=0 are not consumed; the source must hold them.
// TESTING
//  1 start; bytes 02,01,00,05,03,02,07 -> writes addr0=0x10005 and addr1=0x30207;
//    done pulses 1 cycle after the 2nd write; cpu_hold low the next cycle.
//  2 Same stream with in_valid low 3 cycles between every byte -> identical writes;
//    in_ready stays 1 during gaps; no extra wr_en.
//  3 start; byte 00 -> no wr_en; done pulses the cycle after the count transfer;
//    err=0.
//  4 ADDR_W=5, start; byte 21 (N=33) -> err=1, return to IDLE, no wr_en, done=0;
//    next start clears err.
//  5 N=32 with full stream -> 32 writes at addr 0..31 in order; done; no write
//    at addr 0 repeated.
//  6 N=3, assert reset low after the 2nd write and mid-word -> outputs 0 at once;
//    no 3rd write. Then in the same run: start asserted during B1 is ignored, and
//    B0 byte F4 gives op=4 with err=1.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: byte-stream program loader. Packs a count byte plus 3 bytes per word
// into 20-bit instructions written to instruction memory from address 0, holding the CPU.
module instr_loader #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  localparam logic [8:0] DEPTH_C = 9'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_B0    = 3'd2,
    ST_B1    = 3'd3,
    ST_B2    = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [7:0]          n_r;
  logic [ADDR_W:0]     word_cnt_r;
  logic [ADDR_W:0]     cnt_next_s;
  logic [3:0]          op_r;
  logic [7:0]          first_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [INSTR_W-1:0]  wr_data_r;
  logic                err_r;
  logic                in_ready_s;
  logic                xfer_s;
  logic                n_zero_s;
  logic                n_big_s;
  logic                last_word_s;

  function automatic logic [INSTR_W-1:0] pack_word(input logic [3:0] op,
                                                   input logic [7:0] first,
                                                   input logic [7:0] second);
    pack_word = {op, first, second};
  endfunction

  assign in_ready_s  = (state_r == ST_COUNT) || (state_r == ST_B0) ||
                       (state_r == ST_B1)    || (state_r == ST_B2);
  assign xfer_s      = in_valid & in_ready_s;
  assign n_zero_s    = (in_data == 8'd0);
  assign n_big_s     = ({1'b0, in_data} > DEPTH_C);
  assign cnt_next_s  = word_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word_s = (9'(cnt_next_s) == {1'b0, n_r});

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_COUNT;
        else       next_state_s = ST_IDLE;
      end
      ST_COUNT: begin
        if (!xfer_s)       next_state_s = ST_COUNT;
        else if (n_zero_s) next_state_s = ST_DONE;
        else if (n_big_s)  next_state_s = ST_IDLE;
        else               next_state_s = ST_B0;
      end
      ST_B0: begin
        if (xfer_s) next_state_s = ST_B1;
        else        next_state_s = ST_B0;
      end
      ST_B1: begin
        if (xfer_s) next_state_s = ST_B2;
        else        next_state_s = ST_B1;
      end
      ST_B2: begin
        if (xfer_s) next_state_s = ST_WRITE;
        else        next_state_s = ST_B2;
      end
      ST_WRITE: begin
        if (last_word_s) next_state_s = ST_DONE;
        else             next_state_s = ST_B0;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Count, byte capture, write word staging and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_r        <= 8'd0;
      word_cnt_r <= '0;
      op_r       <= 4'd0;
      first_r    <= 8'd0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) err_r <= 1'b0;
        end
        ST_COUNT: begin
          if (xfer_s) begin
            n_r        <= in_data;
            word_cnt_r <= '0;
            if (n_big_s) err_r <= 1'b1;
          end
        end
        ST_B0: begin
          if (xfer_s) begin
            op_r <= in_data[3:0];
            if (in_data[7:4] != 4'd0) err_r <= 1'b1;
          end
        end
        ST_B1: begin
          if (xfer_s) first_r <= in_data;
        end
        ST_B2: begin
          // Stage the word here so wr_addr/wr_data are already stable during WRITE
          if (xfer_s) begin
            wr_addr_r <= word_cnt_r[ADDR_W-1:0];
            wr_data_r <= pack_word(op_r, first_r, in_data);
          end
        end
        ST_WRITE: word_cnt_r <= cnt_next_s;
        default: ;
      endcase
    end
  end

  assign in_ready = in_ready_s;
  assign wr_en    = (state_r == ST_WRITE);
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign cpu_hold = (state_r != ST_IDLE);
  assign done     = (state_r == ST_DONE);
  assign err      = err_r;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table vectors, hand sequences and random loads for instr_loader,
// checked against a word-list model built from the loader's byte-stream rules.
module tb_instr_loader;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 20;
  localparam int DEPTH   = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               cpu_hold;
  logic               done;
  logic               err;

  instr_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [ADDR_W-1:0]  wa_q[$];
  logic [INSTR_W-1:0] wd_q[$];
  int                 wc_q[$];
  int                 done_cnt = 0;
  int                 done_cyc = -1;
  int                 fall_cyc = -1;
  logic               hold_prev = 1'b0;

  logic [7:0]         stream_q[$];
  logic [INSTR_W-1:0] exp_q[$];
  logic               exp_err;
  logic               exp_done;
  int                 base_w;
  int                 base_d;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (!cpu_hold && hold_prev) fall_cyc <= cyc;
    hold_prev <= cpu_hold;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic begin_load();
    base_w = wa_q.size();
    base_d = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_after_start", 32'(cpu_hold), 32'd1);
    chk("err_clr_on_start", 32'(err), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
      chk("ready_in_gap", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic feed(input int gmin, input int gmax);
    foreach (stream_q[i]) send_byte(stream_q[i], int'($urandom_range(gmax, gmin)));
  endtask

  task automatic wait_idle();
    int t = 0;
    while (cpu_hold && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("idle_timeout", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Reference: N words of {b0[3:0], b1, b2} at addresses 0..N-1; N>DEPTH rejected
  task automatic model_stream();
    int n;
    logic [7:0] b0;
    n = int'(stream_q[0]);
    exp_q.delete();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    if (n > DEPTH) begin
      exp_err = 1'b1;
    end else begin
      exp_done = 1'b1;
      for (int i = 0; i < n; i++) begin
        b0 = stream_q[1 + 3 * i];
        exp_q.push_back({b0[3:0], stream_q[2 + 3 * i], stream_q[3 + 3 * i]});
        if (b0 > 8'h0F) exp_err = 1'b1;
      end
    end
  endtask

  task automatic check_load(input string tag);
    int nw;
    nw = wa_q.size() - base_w;
    chk({tag, "_nwrites"}, nw, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base_w + i < wa_q.size()) begin
        chk({tag, "_addr"}, 32'(wa_q[base_w + i]), i);
        chk({tag, "_data"}, 32'(wd_q[base_w + i]), 32'(exp_q[i]));
      end
    end
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_done_cnt"}, done_cnt - base_d, exp_done ? 32'd1 : 32'd0);
    if (exp_done && exp_q.size() > 0 && nw > 0)
      chk({tag, "_done_lat"}, done_cyc, wc_q[wc_q.size() - 1] + 1);
    if (exp_done) chk({tag, "_hold_fall"}, fall_cyc, done_cyc + 1);
  endtask

  task automatic random_stream(input int n);
    logic [7:0] b0;
    stream_q.delete();
    stream_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      b0 = 8'($urandom_range(255, 0));
      if ($urandom_range(3, 0) != 0) b0 = b0 & 8'h0F;
      stream_q.push_back(b0);
      stream_q.push_back(8'($urandom_range(255, 0)));
      stream_q.push_back(8'($urandom_range(255, 0)));
    end
  endtask

  typedef struct {
    logic [7:0]         cnt;
    logic [7:0]         b0;
    logic [7:0]         b1;
    logic [7:0]         b2;
    int                 nw;
    logic [INSTR_W-1:0] data;
    logic               err;
    logic               done;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{8'h01, 8'h01, 8'h00, 8'h05, 1, 20'h10005, 1'b0, 1'b1};
    vt[1] = '{8'h01, 8'hF4, 8'hAB, 8'hCD, 1, 20'h4ABCD, 1'b1, 1'b1};
    vt[2] = '{8'h01, 8'h0F, 8'hFF, 8'hFF, 1, 20'hFFFFF, 1'b0, 1'b1};
    vt[3] = '{8'h01, 8'h80, 8'h12, 8'h34, 1, 20'h01234, 1'b1, 1'b1};
    vt[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 0, 20'h00000, 1'b0, 1'b1};
    vt[5] = '{8'h21, 8'h00, 8'h00, 8'h00, 0, 20'h00000, 1'b1, 1'b0};
    vt[6] = '{8'hFF, 8'h00, 8'h00, 8'h00, 0, 20'h00000, 1'b1, 1'b0};

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two-word load, back-to-back bytes, then with 3-cycle gaps
    for (int pass = 0; pass < 2; pass++) begin
      stream_q = '{8'h02, 8'h01, 8'h00, 8'h05, 8'h03, 8'h02, 8'h07};
      exp_q = '{20'h10005, 20'h30207};
      exp_err = 1'b0; exp_done = 1'b1;
      begin_load();
      feed(3 * pass, 3 * pass);
      wait_idle();
      check_load(pass == 0 ? "two_word" : "two_word_gaps");
    end

    // Table-driven single-word and count-boundary vectors
    for (int v = 0; v < 7; v++) begin
      stream_q.delete();
      stream_q.push_back(vt[v].cnt);
      if (vt[v].cnt == 8'h01) begin
        stream_q.push_back(vt[v].b0);
        stream_q.push_back(vt[v].b1);
        stream_q.push_back(vt[v].b2);
      end
      exp_q.delete();
      if (vt[v].nw == 1) exp_q.push_back(vt[v].data);
      exp_err = vt[v].err; exp_done = vt[v].done;
      begin_load();
      feed(0, 0);
      if (vt[v].cnt == 8'h00) chk("n0_done_now", 32'(done), 32'd1);
      if (vt[v].cnt > 8'h20) chk("nbig_idle_now", 32'(cpu_hold), 32'd0);
      wait_idle();
      check_load("table");
    end

    // Full-depth load and random loads against the reference model
    for (int r = 0; r < 8; r++) begin
      random_stream(r == 0 ? DEPTH : int'($urandom_range(DEPTH, 1)));
      model_stream();
      begin_load();
      feed(0, r % 3);
      wait_idle();
      check_load(r == 0 ? "full_depth" : "random");
    end

    // Reset mid-word after two writes of a three-word load
    random_stream(3);
    begin_load();
    for (int i = 0; i < 9; i++) send_byte(stream_q[i], 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("mid_rst_nwrites", wa_q.size() - base_w, 32'd2);

    // Start during B1 is ignored; upper nibble of B0 flags err
    stream_q = '{8'h01, 8'hF4, 8'hAB, 8'hCD};
    exp_q = '{20'h4ABCD};
    exp_err = 1'b1; exp_done = 1'b1;
    begin_load();
    send_byte(8'h01, 0);
    send_byte(8'hF4, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b1_start_ready", 32'(in_ready), 32'd1);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    wait_idle();
    check_load("start_in_b1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
